starfield_layers: RTL

//  Parallax starfield generator: LAYERS independent Galois LFSR star planes over a 256x256 field, each

---
 rtl/starfield_layers_if.sv | 16 +
 rtl/starfield_layers.sv | 112 +++++++++++
 2 files changed

// File: rtl/starfield_layers_if.sv
// Pixel-side bundle for starfield_layers: raster position in, star colour and skip status out.
interface starfield_layers_if #(
   parameter int unsigned LAYERS = 2
);
   logic [8:0]          hpos;
   logic [8:0]          vpos;
   logic                display_on;
   logic                freeze;
   logic [4*LAYERS-1:0] speed;
   logic [2:0]          rgb;
   logic                star_on;
   logic                busy;

   modport master (output hpos, vpos, display_on, freeze, speed, input rgb, star_on, busy);
   modport slave  (input hpos, vpos, display_on, freeze, speed, output rgb, star_on, busy);
endinterface

// File: rtl/starfield_layers.sv
// Parallax starfield: LAYERS Galois-LFSR star planes over a 256x256 field, each scrolled
// at its own speed by extra LFSR steps inserted during vertical blank.
module starfield_layers #(
   parameter int unsigned       LAYERS  = 2,
   parameter int unsigned       LFSR_W  = 16,
   parameter logic [LFSR_W-1:0] TAPS    = LFSR_W'(16'b1000000001011),
   parameter int unsigned       DENSITY = 7
) (
   input  logic              clk,
   input  logic              reset,
   starfield_layers_if.slave bus
);
   localparam int unsigned       LI_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;
   localparam logic [LFSR_W-1:0] ONES = '1;
   localparam logic [LI_W-1:0]   LAST = LI_W'(LAYERS - 1);

   typedef enum logic {IDLE, SKIP} state_t;

   state_t            state;
   logic [LFSR_W-1:0] lfsr  [LAYERS];
   logic [3:0]        spd_q [LAYERS];
   logic [LI_W-1:0]   li;
   logic [LI_W-1:0]   li_nxt;
   logic [3:0]        cnt;
   logic              prev_v8;
   logic              field_en;
   logic              vis;
   logic              hit_any;
   logic [2:0]        win_rgb;
   logic [LAYERS-1:0] hit;
   logic              unused_pos;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
      return {l[LFSR_W-2:0], 1'b0} ^ (l[LFSR_W-1] ? TAPS : '0);
   endfunction

   assign field_en   = ~bus.hpos[8] & ~bus.vpos[8] & ~bus.freeze;
   assign vis        = bus.display_on & ~bus.hpos[8] & ~bus.vpos[8];
   assign li_nxt     = li + LI_W'(1);
   assign unused_pos = ^{bus.hpos[7:0], bus.vpos[7:0]};

   // Farther layers need one more leading 1 each, so they come out sparser.
   for (genvar g = 0; g < int'(LAYERS); g++) begin : g_hit
      localparam int unsigned D = DENSITY + g;
      assign hit[g] = vis & (&lfsr[g][LFSR_W-1 -: D]);
   end

   // Lowest-index (nearest) hitting layer supplies the colour.
   always_comb begin
      hit_any = 1'b0;
      win_rgb = '0;
      for (int k = 0; k < int'(LAYERS); k++) begin
         if (hit[k] && !hit_any) begin
            hit_any = 1'b1;
            win_rgb = lfsr[k][2:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < int'(LAYERS); k++) begin
            lfsr[k]  <= ONES >> k;
            spd_q[k] <= '0;
         end
         state       <= IDLE;
         li          <= '0;
         cnt         <= '0;
         prev_v8     <= 1'b0;
         bus.rgb     <= '0;
         bus.star_on <= 1'b0;
         bus.busy    <= 1'b0;
      end else begin
         prev_v8     <= bus.vpos[8];
         bus.star_on <= hit_any;
         bus.rgb     <= !hit_any ? 3'b000 : (win_rgb == 3'b000) ? 3'b001 : win_rgb;
         if (field_en) begin
            // Field stepping always wins; an unfinished skip is simply dropped.
            for (int k = 0; k < int'(LAYERS); k++) lfsr[k] <= lfsr_step(lfsr[k]);
            state    <= IDLE;
            bus.busy <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.vpos[8] && !prev_v8 && !bus.freeze) begin
                     for (int k = 0; k < int'(LAYERS); k++) spd_q[k] <= bus.speed[4*k +: 4];
                     li       <= '0;
                     cnt      <= bus.speed[3:0];
                     state    <= SKIP;
                     bus.busy <= 1'b1;
                  end
               end
               SKIP: begin
                  if (!bus.freeze) begin
                     if (cnt != 4'd0) begin
                        lfsr[li] <= lfsr_step(lfsr[li]);
                        cnt      <= cnt - 4'd1;
                     end else if (li == LAST) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                     end else begin
                        li  <= li_nxt;
                        cnt <= spd_q[li_nxt];
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
